// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types for the M-stage data-memory bridge and the load-extraction stage.
// Holds the bridge state encoding and the sram-like access size codes.
package dmem_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } dmem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Request-to-data_ok watchdog: counts busy cycles, hit fires combinationally on the last allowed cycle.
// Flag is sticky until rst; no backpressure, purely observes the bridge state.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic hit,
    output logic flag
);

    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign hit = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            if (start)
                cnt <= '0;
            else if (busy && !hit)
                cnt <= cnt + 1'b1;
            if (hit)
                flag <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage to sram-like data bus bridge; zero-wait access stalls 3 cycles, load word valid in the 4th.
// Stalls the pipe until data_ok, holds readdataM under stall_others; DMEM_TIMEOUT_EN adds a watchdog.
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
`ifdef DMEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [3:0]  memwriteM,
    input  logic [31:0] writedata2M,
    input  logic [31:0] aluoutM,
    input  logic [1:0]  loadsizeM,
    input  logic        flushM,
    input  logic        stall_others,
    output logic        d_stall,
    output logic [31:0] readdataM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        dmem_timeout
);

    dmem_state_t state, state_nxt;
    logic        discard;
    logic        start;
    logic        kill;
    logic        complete;
    logic        tmo_hit;
    logic        tmo_flag;
    logic [1:0]  size_nxt;

    // After a timeout the memory side is considered dead: no further requests until rst.
    assign start    = (state == ST_IDLE) && memenM && !flushM && !tmo_flag;
    assign kill     = discard || flushM;
    assign complete = data_data_ok &&
                      (((state == ST_REQ) && data_addr_ok) || (state == ST_WAIT_DATA));

`ifdef DMEM_TIMEOUT_EN
    logic busy;
    assign busy = (state == ST_REQ) || (state == ST_WAIT_DATA);

    dmem_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .hit   (tmo_hit),
        .flag  (tmo_flag)
    );
`else
    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    assign dmem_timeout = tmo_flag;

    always_comb begin
        size_nxt = loadsizeM;
        if (|memwriteM) begin
            case (memwriteM)
                4'b1111:         size_nxt = SIZE_WORD;
                4'b0011, 4'b1100: size_nxt = SIZE_HALF;
                default:         size_nxt = SIZE_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_REQ;
            ST_REQ:       if (data_addr_ok)
                              state_nxt = complete ? (kill ? ST_IDLE : ST_DONE) : ST_WAIT_DATA;
            ST_WAIT_DATA: if (data_data_ok)
                              state_nxt = kill ? ST_IDLE : ST_DONE;
            ST_DONE:      if (!stall_others) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (tmo_hit)
            state_nxt = ST_IDLE;
    end

    // While a squashed access drains, only a fresh access behind it needs to wait.
    always_comb begin
        data_req = 1'b0;
        d_stall  = 1'b0;
        case (state)
            ST_IDLE:      d_stall = start;
            ST_REQ: begin
                data_req = 1'b1;
                d_stall  = kill ? (memenM && !flushM) : 1'b1;
            end
            ST_WAIT_DATA: d_stall = kill ? (memenM && !flushM) : 1'b1;
            default:      d_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard    <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= '0;
            data_wstrb <= 4'b0000;
            data_wdata <= '0;
            readdataM  <= '0;
        end else begin
            if (start) begin
                discard    <= 1'b0;
                data_wr    <= |memwriteM;
                data_size  <= size_nxt;
                data_addr  <= aluoutM;
                data_wstrb <= memwriteM;
                data_wdata <= writedata2M;
            end else if (((state == ST_REQ) || (state == ST_WAIT_DATA)) && flushM) begin
                discard <= 1'b1;
            end
            if (complete && !data_wr && !kill)
                readdataM <= data_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge with a delay-programmable sram-like slave.
// Define DMEM_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [3:0]  memwriteM;
    logic [31:0] writedata2M;
    logic [31:0] aluoutM;
    logic [1:0]  loadsizeM;
    logic        flushM;
    logic        stall_others;
    logic        d_stall;
    logic [31:0] readdataM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        dmem_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // slave configuration, written only by the stimulus process
    int          addr_dly  = 0;
    int          data_dly  = 0;
    logic        never_ack = 1'b0;
    logic [31:0] slave_rdata = '0;

    int   a_ctr, d_ctr, hs_cnt, dok_cnt;
    logic pend;

    always #5 clk = ~clk;

`ifdef DMEM_TIMEOUT_EN
    dmem_sram_bridge #(.TIMEOUT_CYCLES(8)) dut (
`else
    dmem_sram_bridge dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .writedata2M  (writedata2M),
        .aluoutM      (aluoutM),
        .loadsizeM    (loadsizeM),
        .flushM       (flushM),
        .stall_others (stall_others),
        .d_stall      (d_stall),
        .readdataM    (readdataM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .dmem_timeout (dmem_timeout)
    );

    assign data_addr_ok = data_req && (a_ctr >= addr_dly) && !never_ack;
    assign data_data_ok = pend && (d_ctr >= data_dly);
    assign data_rdata   = slave_rdata;

    always @(posedge clk) begin
        if (rst) begin
            a_ctr <= 0;
            d_ctr <= 0;
            pend  <= 1'b0;
        end else begin
            if (data_req && data_addr_ok) begin
                hs_cnt <= hs_cnt + 1;
                pend   <= 1'b1;
                a_ctr  <= 0;
                d_ctr  <= 0;
            end else if (data_req) begin
                a_ctr <= a_ctr + 1;
            end
            if (pend && data_data_ok) begin
                pend    <= 1'b0;
                dok_cnt <= dok_cnt + 1;
            end else if (pend) begin
                d_ctr <= d_ctr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] ls);
        memenM      = 1'b1;
        memwriteM   = we;
        aluoutM     = addr;
        writedata2M = wd;
        loadsizeM   = ls;
    endtask

    // request fields seen on the bus, and whether they stayed put while data_req was high
    logic        cap_vld;
    logic        cap_wr;
    logic [1:0]  cap_size;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_stable;

    task automatic wait_stall(output int n);
        n          = 0;
        cap_vld    = 1'b0;
        cap_stable = 1'b1;
        #1;
        while (d_stall && n < 64) begin
            tick();
            n++;
            if (data_req) begin
                if (!cap_vld) begin
                    cap_vld   = 1'b1;
                    cap_wr    = data_wr;
                    cap_size  = data_size;
                    cap_wstrb = data_wstrb;
                    cap_addr  = data_addr;
                    cap_wdata = data_wdata;
                end else if (data_wr !== cap_wr || data_size !== cap_size ||
                             data_wstrb !== cap_wstrb || data_addr !== cap_addr ||
                             data_wdata !== cap_wdata) begin
                    cap_stable = 1'b0;
                end
            end
        end
    endtask

    task automatic retire();
        tick();
        memenM    = 1'b0;
        memwriteM = 4'b0000;
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req"},   data_req,     0);
        chk({pfx, "_stall"}, d_stall,      0);
        chk({pfx, "_wr"},    data_wr,      0);
        chk({pfx, "_size"},  data_size,    0);
        chk({pfx, "_addr"},  data_addr,    0);
        chk({pfx, "_wstrb"}, data_wstrb,   0);
        chk({pfx, "_wdata"}, data_wdata,   0);
        chk({pfx, "_rdata"}, readdataM,    0);
        chk({pfx, "_tmo"},   dmem_timeout, 0);
    endtask

    initial begin
        int n;
        int hs0;
        int dok0;
        int bad;

        hs_cnt       = 0;
        dok_cnt      = 0;
        rst          = 1'b1;
        memenM       = 1'b0;
        memwriteM    = 4'b0000;
        writedata2M  = '0;
        aluoutM      = '0;
        loadsizeM    = 2'b00;
        flushM       = 1'b0;
        stall_others = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // word store, zero-wait slave
        hs0 = hs_cnt;
        issue(4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10);
        wait_stall(n);
        chk("sw_stall_cycles", n, 3);
        chk("sw_wr",    cap_wr,    1);
        chk("sw_size",  cap_size,  2'b10);
        chk("sw_wstrb", cap_wstrb, 4'b1111);
        chk("sw_addr",  cap_addr,  32'h1000_0004);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("sw_handshakes", hs_cnt - hs0, 1);
        chk("sw_rdata_untouched", readdataM, 0);
        retire();

        // half store in the upper lane
        issue(4'b1100, 32'h1000_0002, 32'h1234_1234, 2'b00);
        wait_stall(n);
        chk("sh_stall_cycles", n, 3);
        chk("sh_size",  cap_size,  2'b01);
        chk("sh_wstrb", cap_wstrb, 4'b1100);
        chk("sh_addr",  cap_addr,  32'h1000_0002);
        retire();

        // byte store
        issue(4'b0100, 32'h1000_0006, 32'hABAB_ABAB, 2'b10);
        wait_stall(n);
        chk("sb_size", cap_size, 2'b00);
        retire();

        // word load, slow slave: 3 REQ cycles, 3 WAIT cycles
        addr_dly    = 2;
        data_dly    = 2;
        slave_rdata = 32'hCAFE_F00D;
        hs0 = hs_cnt;
        issue(4'b0000, 32'h2000_0008, 32'h0, 2'b10);
        wait_stall(n);
        chk("lw_slow_stall_cycles", n, 7);
        chk("lw_slow_stable", cap_stable, 1);
        chk("lw_slow_wr",   cap_wr,   0);
        chk("lw_slow_size", cap_size, 2'b10);
        chk("lw_slow_rdata", readdataM, 32'hCAFE_F00D);
        chk("lw_slow_handshakes", hs_cnt - hs0, 1);
        retire();

        // half load finishing while another stall source holds the pipe
        addr_dly     = 0;
        data_dly     = 0;
        slave_rdata  = 32'h0BAD_CAFE;
        stall_others = 1'b1;
        hs0 = hs_cnt;
        issue(4'b0000, 32'h3000_0002, 32'h0, 2'b01);
        wait_stall(n);
        chk("lh_hold_stall_cycles", n, 3);
        chk("lh_hold_size", cap_size, 2'b01);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d_stall !== 1'b0 || readdataM !== 32'h0BAD_CAFE || data_req !== 1'b0)
                bad++;
        end
        chk("lh_hold_done_cycles_bad", bad, 0);
        chk("lh_hold_handshakes", hs_cnt - hs0, 1);
        stall_others = 1'b0;
        retire();

        // flush while waiting for data: bus completes, result discarded, no DONE
        data_dly    = 2;
        slave_rdata = 32'h1111_2222;
        dok0 = dok_cnt;
        issue(4'b0000, 32'h4000_0000, 32'h0, 2'b10);
        tick();
        tick();
        flushM = 1'b1;
        #1;
        chk("flush_stall_drop", d_stall, 0);
        tick();
        flushM = 1'b0;
        memenM = 1'b0;
        n = 0;
        while (!data_data_ok && n < 16) begin
            tick();
            n++;
        end
        chk("flush_dok_seen", data_data_ok, 1);
        tick();
        chk("flush_bus_completed", dok_cnt - dok0, 1);
        chk("flush_rdata_kept", readdataM, 32'h0BAD_CAFE);
        chk("flush_req_idle", data_req, 0);
        data_dly    = 0;
        slave_rdata = 32'h55AA_55AA;
        issue(4'b0000, 32'h4000_0004, 32'h0, 2'b10);
        #1;
        chk("flush_back_in_idle", d_stall, 1);
        wait_stall(n);
        chk("after_flush_stall_cycles", n, 3);
        chk("after_flush_rdata", readdataM, 32'h55AA_55AA);
        retire();

        // reset in the middle of REQ
        never_ack = 1'b1;
        issue(4'b1111, 32'h5000_0000, 32'h7777_8888, 2'b10);
        tick();
        chk("midreq_req_up", data_req, 1);
        rst    = 1'b1;
        memenM = 1'b0;
        tick();
        check_reset_outputs("midreq");
        rst       = 1'b0;
        memwriteM = 4'b0000;
        tick();

`ifdef DMEM_TIMEOUT_EN
        // slave never accepts; watchdog gives up after 8 busy cycles
        issue(4'b0000, 32'h6000_0000, 32'h0, 2'b10);
        tick();
        for (int i = 0; i < 7; i++)
            tick();
        chk("tmo_not_yet", dmem_timeout, 0);
        chk("tmo_still_stalled", d_stall, 1);
        tick();
        chk("tmo_flag", dmem_timeout, 1);
        chk("tmo_stall_drop", d_stall, 0);
        chk("tmo_req_drop", data_req, 0);
        retire();
        rst = 1'b1;
        tick();
        chk("tmo_cleared_by_rst", dmem_timeout, 0);
        rst = 1'b0;
        tick();
`endif
        never_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
Memory-stage data-access bridge directly downstream of the store byte-enable/data-replication decoder. It takes the M-stage access (byte enables, replicated write data, address) and runs a registered sram-like req/addr_ok/data_ok transaction toward the data-memory side. It stalls the pipeline until the access completes and holds the returned load word while other stall sources keep the pipeline frozen.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles from request issue to data_ok before timeout error (only with DMEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
memenM  in  1  M-stage instruction performs a load or store
memwriteM  in  4  byte enables from store decode; 0000 = load
writedata2M  in  32  lane-replicated store data
aluoutM  in  32  effective byte address
loadsizeM  in  2  load size: 00 byte, 01 half, 10 word
flushM  in  1  M-stage instruction squashed
stall_others  in  1  pipeline frozen by a non-dmem source
d_stall  out  1  stall request to hazard unit
readdataM  out  32  raw load word (unextracted) valid while d_stall=0 after a load
data_req  out  1  request valid
data_wr  out  1  1 = write
data_size  out  2  00/01/10 byte/half/word
data_addr  out  32  byte address
data_wstrb  out  4  write byte strobes
data_wdata  out  32  write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  write done / read data valid
data_rdata  in  32  read data
dmem_timeout  out  1  sticky timeout flag (macro only)

Behaviour:
- One clock; reset synchronous and active-high; clock port clk, reset port rst.
- Reset: state IDLE; data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, readdataM, discard flag, and dmem_timeout all 0. Reset mid-transaction drops the transaction unconditionally.
- State IDLE:
  - If memenM & !flushM, latch request registers and go to REQ.
  - data_wr = |memwriteM.
  - Store size from strobes: 1111 -> 10; 0011/1100 -> 01; one-hot -> 00. Load size = loadsizeM.
  - d_stall = memenM & !flushM (combinational).
- State REQ:
  - data_req=1; d_stall=1.
  - Request fields are held stable until data_addr_ok. The request is never withdrawn.
  - On addr_ok go to WAIT_DATA. If data_ok is also high in the same cycle, treat as completion directly (see WAIT_DATA).
- State WAIT_DATA:
  - data_req=0; d_stall=1.
  - On data_ok, capture data_rdata into readdataM (loads only; stores leave it unchanged).
  - Then go to DONE, or to IDLE if discard is set.
- State DONE:
  - d_stall=0; readdataM held.
  - Stay in DONE while stall_others=1. When stall_others=0, go to IDLE; the instruction advances this cycle.
  - No new request is issued from DONE, so the same M-stage access is never reissued.
- Flush:
  - flushM in IDLE: no request.
  - flushM in REQ or WAIT_DATA: set discard. The transaction still completes on the bus, then returns to IDLE without DONE. d_stall drops once flushM is seen.
- Minimum latency (zero-wait slave, addr_ok in the first REQ cycle, data_ok one cycle later): d_stall high for 3 cycles; readdataM valid in the 4th.
- memenM with memwriteM=0000 is a load, even for a misaligned store upstream. Exception gating of memenM is done upstream.
- Unexpected data_ok in IDLE or DONE is ignored.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments in REQ/WAIT_DATA.
  - Reaching TIMEOUT_CYCLES sets sticky dmem_timeout, forces the state to IDLE, and drops d_stall.
  - The flag is cleared only by rst.
- Undefined: no counter; dmem_timeout is tied 0; the bridge waits indefinitely.

Decomposition:
- Shared package: state encoding (IDLE/REQ/WAIT_DATA/DONE) and size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD, reused by the load-extraction stage.
- One natural sub-module: dmem_timeout_cnt (counter + sticky flag), instantiated only under DMEM_TIMEOUT_EN.
- Strobe-to-size encoding stays inline.

Test Plan:
- Word store:
  - Stimulus: memenM=1, memwriteM=1111, addr 0x1000_0004, wdata 0xDEADBEEF, zero-wait slave.
  - Required: one req with wr=1, size=10, wstrb=1111; d_stall high exactly 3 cycles.
- Half store:
  - Stimulus: memwriteM=1100, addr 0x...02, wdata 0x12341234.
  - Required: size=01, wstrb=1100, data_addr=0x...02.
- Word load with slow slave:
  - Stimulus: addr_ok delayed 2 cycles, data_ok 3 cycles later with rdata 0xCAFEF00D.
  - Required: req held stable throughout; readdataM=0xCAFEF00D after data_ok; d_stall deasserts the next cycle.
- Load finishes under stall_others:
  - Stimulus: load completes while stall_others=1 for 4 cycles.
  - Required: stays in DONE; d_stall=0; readdataM stable; exactly one data_req handshake.
- Flush during WAIT_DATA:
  - Required: transaction completes on the bus; readdataM unchanged; returns to IDLE; no DONE.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - Stimulus: slave never asserts addr_ok.
  - Required: dmem_timeout=1 after 8 cycles; d_stall=0.
- Reset asserted mid-REQ:
  - Required: all outputs 0 on the next edge.
